// File: rtl/vector_dot_product_stream.sv
// Streaming LANES-wide dot product over multi-beat packets; last beat accepted at edge k gives out_valid after edge k+2.
// One packet in flight: in_ready drops from the last accepted beat until the result is taken by out_ready.
module vector_dot_product_stream #(
  parameter int LANES = 8,
  parameter int DW    = 8,
  parameter int ACC_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  input  logic                  signed_mode,
  input  logic [LANES*DW-1:0]   t_data,
  input  logic [LANES*DW-1:0]   weights,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_W-1:0]      dot_product,
  output logic                  overflow
);

  localparam int PW = 2 * DW;
  localparam int SW = PW + $clog2(LANES);

  generate
    if (LANES < 1 || ACC_W < SW) begin : g_param_check
      $error("vector_dot_product_stream: ACC_W must be >= 2*DW+$clog2(LANES) and LANES >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_t;

  state_t                  state_q, state_d;
  logic                    mode_q, mode_d;
  logic                    p1_vld_q, p1_vld_d, p1_first_q, p1_first_d, p1_last_q, p1_last_d;
  logic [LANES-1:0][PW-1:0] prod_q, prod_d;
  logic                    p2_vld_q, p2_vld_d, p2_first_q, p2_first_d, p2_last_q, p2_last_d;
  logic [SW-1:0]           sum_q, sum_d;
  logic [ACC_W-1:0]        acc_q, acc_d;
  logic                    ovf_q, ovf_d;

  logic                    accept, first_beat, lane_mode;
  logic [ACC_W-1:0]        acc_base, addend, add_res;
  logic                    add_c, add_ov;

  // Low PW bits of the product of the PW-wide extended operands are exact for both modes.
  function automatic logic [PW-1:0] lane_mul(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                             input logic sgn);
    logic [PW-1:0] ax, bx;
    ax = {{DW{sgn & a[DW-1]}}, a};
    bx = {{DW{sgn & b[DW-1]}}, b};
    return ax * bx;
  endfunction

  assign in_ready    = !rst && (state_q == IDLE || state_q == ACCUM);
  assign accept      = in_valid && in_ready;
  assign first_beat  = (state_q == IDLE);
  // The first beat's products use the live mode; mode_q is only valid from the next cycle.
  assign lane_mode   = first_beat ? signed_mode : mode_q;
  assign out_valid   = (state_q == HOLD);
  assign dot_product = acc_q;
  assign overflow    = ovf_q;

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    p1_vld_d   = accept;
    p1_first_d = first_beat;
    p1_last_d  = in_last;
    prod_d     = prod_q;
    p2_vld_d   = p1_vld_q;
    p2_first_d = p1_first_q;
    p2_last_d  = p1_last_q;
    sum_d      = sum_q;
    acc_d      = acc_q;
    ovf_d      = ovf_q;
    acc_base   = '0;
    addend     = '0;
    add_res    = '0;
    add_c      = 1'b0;
    add_ov     = 1'b0;

    if (accept) begin
      if (first_beat) mode_d = signed_mode;
      for (int i = 0; i < LANES; i++) begin
        prod_d[i] = lane_mul(t_data[i*DW +: DW], weights[i*DW +: DW], lane_mode);
      end
    end

    if (p1_vld_q) begin
      sum_d = '0;
      for (int i = 0; i < LANES; i++) begin
        if (mode_q) sum_d = sum_d + SW'($signed(prod_q[i]));
        else        sum_d = sum_d + SW'(prod_q[i]);
      end
    end

    if (p2_vld_q) begin
      acc_base = p2_first_q ? '0 : acc_q;
      if (mode_q) addend = ACC_W'($signed(sum_q));
      else        addend = ACC_W'(sum_q);
      {add_c, add_res} = {1'b0, acc_base} + {1'b0, addend};
      if (mode_q) add_ov = (acc_base[ACC_W-1] == addend[ACC_W-1]) &&
                           (add_res[ACC_W-1] != acc_base[ACC_W-1]);
      else        add_ov = add_c;
      acc_d = add_res;
      ovf_d = add_ov | (ovf_q & ~p2_first_q);
    end

    case (state_q)
      IDLE:    if (accept) state_d = in_last ? DRAIN : ACCUM;
      ACCUM:   if (accept && in_last) state_d = DRAIN;
      DRAIN:   if (p2_vld_q && p2_last_q) state_d = HOLD;
      HOLD:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      mode_q     <= 1'b0;
      p1_vld_q   <= 1'b0;
      p1_first_q <= 1'b0;
      p1_last_q  <= 1'b0;
      prod_q     <= '0;
      p2_vld_q   <= 1'b0;
      p2_first_q <= 1'b0;
      p2_last_q  <= 1'b0;
      sum_q      <= '0;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      p1_vld_q   <= p1_vld_d;
      p1_first_q <= p1_first_d;
      p1_last_q  <= p1_last_d;
      prod_q     <= prod_d;
      p2_vld_q   <= p2_vld_d;
      p2_first_q <= p2_first_d;
      p2_last_q  <= p2_last_d;
      sum_q      <= sum_d;
      acc_q      <= acc_d;
      ovf_q      <= ovf_d;
    end
  end

endmodule

// File: tb/tb_vector_dot_product_stream.sv
// Scoreboard bench: two 8x8-bit engines (ACC_W 32 and the minimum legal 19) share one stimulus stream.
module tb_vector_dot_product_stream;

  localparam int LANES = 8;
  localparam int DW    = 8;
  localparam int WA    = 32;
  localparam int WB    = 2 * DW + $clog2(LANES);

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  in_valid = 1'b0, in_last = 1'b0, signed_mode = 1'b0, out_ready = 1'b1;
  logic [LANES*DW-1:0]   t_data = '0, weights = '0;
  logic                  in_ready, out_valid, ov_a, in_ready_b, out_valid_b, ov_b;
  logic [WA-1:0]         dot_a;
  logic [WB-1:0]         dot_b;

  vector_dot_product_stream #(.LANES(LANES), .DW(DW), .ACC_W(WA)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .signed_mode(signed_mode), .t_data(t_data), .weights(weights), .out_valid(out_valid),
    .out_ready(out_ready), .dot_product(dot_a), .overflow(ov_a));

  vector_dot_product_stream #(.LANES(LANES), .DW(DW), .ACC_W(WB)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .in_last(in_last),
    .signed_mode(signed_mode), .t_data(t_data), .weights(weights), .out_valid(out_valid_b),
    .out_ready(out_ready), .dot_product(dot_b), .overflow(ov_b));

  always #5 clk = ~clk;

  typedef struct {
    longint va;
    bit     oa;
    longint vb;
    bit     ob;
    int     acc_cyc;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   ready_mode = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Reference: per-beat exact dot product of the interpreted lane values.
  function automatic longint beat_sum(input logic [LANES*DW-1:0] t, input logic [LANES*DW-1:0] w,
                                      input bit sgn);
    longint s = 0;
    for (int i = 0; i < LANES; i++) begin
      longint a = longint'(t[i*DW +: DW]);
      longint b = longint'(w[i*DW +: DW]);
      if (sgn && a >= (longint'(1) << (DW - 1))) a -= (longint'(1) << DW);
      if (sgn && b >= (longint'(1) << (DW - 1))) b -= (longint'(1) << DW);
      s += a * b;
    end
    return s;
  endfunction

  // Reference: running total in a W-bit register, flagging any step that leaves the representable range.
  function automatic void fold(input longint sums[$], input bit sgn, input int w,
                               output longint val, output bit ov);
    longint m    = longint'(1) << w;
    longint half = m / 2;
    longint acc  = 0;
    ov = 1'b0;
    foreach (sums[j]) begin
      acc += sums[j];
      if (sgn && (acc >= half || acc < -half)) ov = 1'b1;
      if (!sgn && acc >= m) ov = 1'b1;
      acc = ((acc % m) + m) % m;
      if (sgn && acc >= half) acc -= m;
    end
    val = (acc < 0) ? acc + m : acc;
  endfunction

  function automatic logic [LANES*DW-1:0] rand_vec();
    logic [LANES*DW-1:0] v;
    for (int i = 0; i < LANES; i++) begin
      case ($urandom_range(0, 3))
        0:       v[i*DW +: DW] = ($urandom_range(0, 1) == 1) ? 8'h80 : 8'hFF;
        1:       v[i*DW +: DW] = 8'($urandom_range(0, 15));
        default: v[i*DW +: DW] = 8'($urandom_range(0, 255));
      endcase
    end
    return v;
  endfunction

  function automatic logic [LANES*DW-1:0] splat(input logic [DW-1:0] x);
    logic [LANES*DW-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*DW +: DW] = x;
    return v;
  endfunction

  task automatic idle_cycles(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_last = ($urandom_range(0, 1) == 1);
      t_data  = rand_vec();
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one packet; complete=0 sends the beats without in_last and expects no result.
  task automatic send_packet(input logic [LANES*DW-1:0] ts[$], input logic [LANES*DW-1:0] ws[$],
                             input bit sgn, input int gap_max, input bit flip, input bit complete);
    longint sums[$];
    exp_t   e;
    for (int j = 0; j < ts.size(); j++) begin
      bit ok = 1'b0;
      int guard = 0;
      if (j > 0 && gap_max > 0) idle_cycles($urandom_range(0, gap_max));
      in_valid    = 1'b1;
      in_last     = complete && (j == ts.size() - 1);
      signed_mode = (j == 0 || !flip) ? sgn : ($urandom_range(0, 1) == 1);
      t_data      = ts[j];
      weights     = ws[j];
      while (!ok) begin
        @(negedge clk);
        ok = in_ready;
        @(posedge clk);
        #1;
        guard++;
        if (!ok && guard > 300) begin
          check("accept_timeout", 0, 1);
          ok = 1'b1;
        end
      end
      sums.push_back(beat_sum(ts[j], ws[j], sgn));
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (complete) begin
      fold(sums, sgn, WA, e.va, e.oa);
      fold(sums, sgn, WB, e.vb, e.ob);
      e.acc_cyc = cyc;
      sb_q.push_back(e);
    end
  endtask

  task automatic wait_drain();
    int g = 0;
    while (sb_q.size() != 0 && g < 2000) begin
      @(posedge clk);
      g++;
    end
    #1;
    if (sb_q.size() != 0) check("drain_timeout", sb_q.size(), 0);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_out_valid", out_valid, 0);
    check("post_rst_dot", dot_a, 0);
    check("post_rst_ovf", ov_a, 0);
    check("post_rst_dot_b", dot_b, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 1)      out_ready = ($urandom_range(0, 3) != 0);
      else if (ready_mode == 0) out_ready = 1'b1;
      else                      out_ready = 1'b0;
    end
  end

  // Monitor: pops and compares on each handshake, checks latency, hold stability and ready recovery.
  initial begin
    bit            prev_ov = 1'b0, prev_hs = 1'b0;
    logic [WA-1:0] held_a = '0;
    logic          held_oa = 1'b0;
    exp_t          e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_ov = 1'b0;
        prev_hs = 1'b0;
      end else begin
        check("lockstep", {out_valid_b, in_ready_b}, {out_valid, in_ready});
        if (prev_hs) begin
          check("post_hs_in_ready", in_ready, 1);
          check("post_hs_out_valid", out_valid, 0);
        end
        if (prev_ov) check("valid_held", out_valid, 1);
        if (out_valid) begin
          check("busy_in_ready", in_ready, 0);
          if (prev_ov) begin
            check("hold_dot", dot_a, held_a);
            check("hold_ovf", ov_a, held_oa);
          end else if (sb_q.size() == 0) begin
            check("unexpected_output", 1, 0);
          end else begin
            check("latency", cyc, sb_q[0].acc_cyc + 2);
          end
          held_a  = dot_a;
          held_oa = ov_a;
          if (out_ready && sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("dot_a", dot_a, e.va);
            check("ovf_a", ov_a, e.oa);
            check("dot_b", dot_b, e.vb);
            check("ovf_b", ov_b, e.ob);
          end
        end
        prev_hs = out_valid && out_ready;
        prev_ov = out_valid && !out_ready;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, got cycle %0d, expected completion", cyc);
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LANES*DW-1:0] ts[$], ws[$];
    logic [LANES*DW-1:0] lane0;
    @(posedge clk);
    #1;
    do_reset();

    // Single unsigned beat: 8 lanes of 3*4.
    ts = '{splat(8'd3)};
    ws = '{splat(8'd4)};
    send_packet(ts, ws, 1'b0, 0, 1'b0, 1'b1);
    wait_drain();
    check("t1_dot", dot_a, 96);
    check("t1_ovf", ov_a, 0);

    // Lane 0 only, -2 * 5 over three beats with gaps, signed then unsigned.
    lane0 = '0;
    lane0[DW-1:0] = 8'hFE;
    ts = '{lane0, lane0, lane0};
    lane0[DW-1:0] = 8'd5;
    ws = '{lane0, lane0, lane0};
    send_packet(ts, ws, 1'b1, 3, 1'b1, 1'b1);
    wait_drain();
    check("t2_signed", dot_a, 64'hFFFF_FFE2);
    send_packet(ts, ws, 1'b0, 3, 1'b1, 1'b1);
    wait_drain();
    check("t2_unsigned", dot_a, 3810);

    // Backpressure: result held for 10+ cycles, then back-to-back packet.
    ready_mode = 2;
    out_ready  = 1'b0;
    ts = '{rand_vec(), rand_vec()};
    ws = '{rand_vec(), rand_vec()};
    send_packet(ts, ws, 1'b1, 0, 1'b0, 1'b1);
    repeat (12) @(posedge clk);
    #1;
    check("t3_held_valid", out_valid, 1);
    check("t3_held_in_ready", in_ready, 0);
    ready_mode = 0;
    out_ready  = 1'b1;
    ts = '{rand_vec()};
    ws = '{rand_vec()};
    send_packet(ts, ws, 1'b0, 0, 1'b0, 1'b1);
    wait_drain();

    // Narrow accumulator wraps: 2 beats of 8*255*255 = 1040400.
    ts = '{splat(8'hFF), splat(8'hFF)};
    ws = '{splat(8'hFF), splat(8'hFF)};
    send_packet(ts, ws, 1'b0, 0, 1'b0, 1'b1);
    wait_drain();
    check("t4_dot_b", dot_b, 1040400 - 524288);
    check("t4_ovf_b", ov_b, 1);
    check("t4_ovf_a", ov_a, 0);
    ts = '{splat(8'd1)};
    ws = '{splat(8'd2)};
    send_packet(ts, ws, 1'b0, 0, 1'b0, 1'b1);
    wait_drain();
    check("t4_clean_ovf_b", ov_b, 0);

    // Reset mid-packet: aborted beats leave no residue.
    ts = '{splat(8'd9), splat(8'd9)};
    ws = '{splat(8'd7), splat(8'd7)};
    send_packet(ts, ws, 1'b0, 0, 1'b0, 1'b0);
    do_reset();
    ts = '{splat(8'd1)};
    ws = '{splat(8'd1)};
    send_packet(ts, ws, 1'b0, 0, 1'b0, 1'b1);
    wait_drain();
    check("t5_dot", dot_a, LANES);

    // Randomised packets with stalls and mid-packet mode flips.
    ready_mode = 1;
    for (int p = 0; p < 1000; p++) begin
      int nb = $urandom_range(1, 6);
      ts.delete();
      ws.delete();
      for (int j = 0; j < nb; j++) begin
        ts.push_back(rand_vec());
        ws.push_back(rand_vec());
      end
      send_packet(ts, ws, ($urandom_range(0, 1) == 1), 2, 1'b1, 1'b1);
    end
    wait_drain();
    check("sb_empty", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
